// File: rtl/dff_pipe_if.sv
// Handshake bundle for dff_pipe: upstream valid/ready/data, flush, downstream valid/ready/data.
// The DUT attaches through the slave modport; the environment drives through master.
interface dff_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dff_pipe.sv
// Elastic register pipeline of DEPTH stages with valid/ready handshake, bubble collapse and flush.
// Define DFF_PIPE_COUNT_EN to add the registered occupancy output.
module dff_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  dff_pipe_if.slave bus
`ifdef DFF_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0]            v_c;
  logic [DEPTH-1:0]            adv_c;
  logic [DEPTH-1:0]            nv_c;
  logic [DEPTH-1:0][WIDTH-1:0] data_c;
  logic                        in_ready_c;

  // A stall reaches stage 0 only when every stage is full and downstream refuses.
  assign in_ready_c    = bus.out_ready | ~(&v_c);
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v_c[DEPTH-1];
  assign bus.out_data  = data_c[DEPTH-1];

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
    logic [WIDTH-1:0] d_q;
    logic             vld_q;
    logic             ld_c;
    logic [WIDTH-1:0] src_c;

    if (g == 0) begin : g_head
      assign ld_c  = bus.in_valid & in_ready_c & ~bus.flush;
      assign src_c = bus.in_data;
    end else begin : g_body
      assign ld_c  = adv_c[g-1] & ~bus.flush;
      assign src_c = data_c[g-1];
    end

    // A stage advances when its word can move into a free or vacating slot ahead.
    if (g == int'(DEPTH) - 1) begin : g_last
      assign adv_c[g] = vld_q & bus.out_ready;
    end else begin : g_mid
      assign adv_c[g] = vld_q & (bus.out_ready | ~(&v_c[DEPTH-1:g+1]));
    end

    assign nv_c[g]   = ~bus.flush & (ld_c | (vld_q & ~adv_c[g]));
    assign v_c[g]    = vld_q;
    assign data_c[g] = d_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q   <= '0;
        vld_q <= 1'b0;
      end else begin
        if (ld_c) d_q <= src_c;
        vld_q <= nv_c[g];
      end
    end
  end

`ifdef DFF_PIPE_COUNT_EN
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  logic [CNT_W-1:0] occ_q;

  // Count follows the next-state valid bits so it lines up with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= CNT_W'($countones(nv_c));
  end

  assign occupancy = occ_q;
`endif

endmodule
